// File: rtl/string_scheduler.sv
// Round-robin fetch of one frame of pixels from a shared RAM read port into a bank
// of WS2812B string drivers; each string gets LEDS_PER_STRING pixels then one h_blank.
module string_scheduler #(
  parameter int NUM_STRINGS     = 4,
  parameter int LEDS_PER_STRING = 150,
  parameter int ADDR_W          = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [23:0]            mem_rdata,
  input  logic [NUM_STRINGS-1:0] string_ready,
  output logic [23:0]            pixel_data,
  output logic [NUM_STRINGS-1:0] pixel_valid,
  output logic [NUM_STRINGS-1:0] h_blank
);

  localparam int         IDX_W        = $clog2(LEDS_PER_STRING + 1);
  localparam int         PTR_W        = (NUM_STRINGS > 1) ? $clog2(NUM_STRINGS) : 1;
  localparam logic [2:0] HOLDOFF_LOAD = 3'd4;

  typedef enum logic {G_IDLE = 1'b0, G_RUN = 1'b1} gstate_t;
  typedef enum logic [1:0] {S_PIX = 2'd0, S_BLANK = 2'd1, S_DONE = 2'd2} sstate_t;

  gstate_t                r_gstate;
  gstate_t                w_gstate_nxt;
  sstate_t                r_sstate  [NUM_STRINGS];
  logic [IDX_W-1:0]       r_idx     [NUM_STRINGS];
  logic [ADDR_W-1:0]      r_addr    [NUM_STRINGS];
  logic [2:0]             r_holdoff [NUM_STRINGS];
  logic [PTR_W-1:0]       r_ptr;

  logic [PTR_W-1:0]       r_rd_sel;
  logic                   r_blank_vld;
  logic [PTR_W-1:0]       r_blank_sel;
  logic                   r_cap_vld;
  logic [PTR_W-1:0]       r_cap_sel;

  logic [NUM_STRINGS-1:0] w_eligible;
  logic                   w_all_quiet;
  logic                   w_start;
  logic                   w_finish;
  logic                   w_busy_nxt;
  logic                   w_grant;
  logic                   w_grant_pix;
  logic [PTR_W-1:0]       w_grant_sel;
  logic [ADDR_W-1:0]      w_grant_addr;

  // Per-string eligibility and the frame-complete condition
  always_comb begin
    w_eligible  = '0;
    w_all_quiet = 1'b1;
    for (int s = 0; s < NUM_STRINGS; s++) begin
      w_eligible[s] = (r_gstate == G_RUN) && string_ready[s] &&
                      (r_holdoff[s] == 3'd0) && (r_sstate[s] != S_DONE);
      w_all_quiet   = w_all_quiet && (r_sstate[s] == S_DONE) &&
                      (r_holdoff[s] == 3'd0) && string_ready[s];
    end
  end

  // Round-robin arbiter: nearest eligible string at or after the pointer wins
  always_comb begin
    w_grant      = 1'b0;
    w_grant_pix  = 1'b0;
    w_grant_sel  = '0;
    w_grant_addr = '0;
    for (int k = 0; k < NUM_STRINGS; k++) begin
      for (int s = 0; s < NUM_STRINGS; s++) begin
        if (!w_grant && w_eligible[s] && (((int'(r_ptr) + k) % NUM_STRINGS) == s)) begin
          w_grant      = 1'b1;
          w_grant_sel  = PTR_W'(s);
          w_grant_pix  = (r_sstate[s] == S_PIX);
          w_grant_addr = r_addr[s];
        end else begin
          w_grant      = w_grant;
        end
      end
    end
  end

  // Global state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gstate <= G_IDLE;
    end else begin
      r_gstate <= w_gstate_nxt;
    end
  end

  // Global next-state logic
  always_comb begin
    case (r_gstate)
      G_IDLE:  w_gstate_nxt = w_start  ? G_RUN  : G_IDLE;
      G_RUN:   w_gstate_nxt = w_finish ? G_IDLE : G_RUN;
      default: w_gstate_nxt = G_IDLE;
    endcase
  end

  // Global output decode; frame_start while running is simply not decoded
  always_comb begin
    w_start  = (r_gstate == G_IDLE) && frame_start;
    w_finish = (r_gstate == G_RUN) && w_all_quiet;
    if (w_start) begin
      w_busy_nxt = 1'b1;
    end else if (w_finish) begin
      w_busy_nxt = 1'b0;
    end else begin
      w_busy_nxt = frame_busy;
    end
  end

  // Frame status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_busy <= w_busy_nxt;
      frame_done <= w_finish;
    end
  end

  // Per-string progress; holdoff spans the fetch pipeline plus the driver's ready lag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_STRINGS; s++) begin
        r_sstate[s]  <= S_PIX;
        r_idx[s]     <= '0;
        r_addr[s]    <= '0;
        r_holdoff[s] <= 3'd0;
      end
    end else if (w_start) begin
      for (int s = 0; s < NUM_STRINGS; s++) begin
        r_sstate[s]  <= S_PIX;
        r_idx[s]     <= '0;
        r_addr[s]    <= ADDR_W'(s * LEDS_PER_STRING);
        r_holdoff[s] <= 3'd0;
      end
    end else begin
      for (int s = 0; s < NUM_STRINGS; s++) begin
        if (w_grant && (w_grant_sel == PTR_W'(s))) begin
          r_holdoff[s] <= HOLDOFF_LOAD;
          if (r_sstate[s] == S_PIX) begin
            r_addr[s] <= r_addr[s] + ADDR_W'(1);
            r_idx[s]  <= r_idx[s] + IDX_W'(1);
            r_sstate[s] <= (r_idx[s] == IDX_W'(LEDS_PER_STRING - 1)) ? S_BLANK : S_PIX;
          end else begin
            r_sstate[s] <= S_DONE;
          end
        end else if (r_holdoff[s] != 3'd0) begin
          r_holdoff[s] <= r_holdoff[s] - 3'd1;
        end else begin
          r_holdoff[s] <= r_holdoff[s];
        end
      end
    end
  end

  // Round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_grant_sel == PTR_W'(NUM_STRINGS - 1)) ? '0 : w_grant_sel + PTR_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Issue stage: RAM read strobe or pending blank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      r_rd_sel    <= '0;
      r_blank_vld <= 1'b0;
      r_blank_sel <= '0;
    end else begin
      mem_rd      <= w_grant && w_grant_pix;
      mem_addr    <= (w_grant && w_grant_pix) ? w_grant_addr : '0;
      r_rd_sel    <= w_grant_sel;
      r_blank_vld <= w_grant && !w_grant_pix;
      r_blank_sel <= w_grant_sel;
    end
  end

  // Delivery stage: capture RAM data the cycle after the read and strobe the owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_vld   <= 1'b0;
      r_cap_sel   <= '0;
      h_blank     <= '0;
      pixel_valid <= '0;
      pixel_data  <= 24'h000000;
    end else begin
      r_cap_vld   <= mem_rd;
      r_cap_sel   <= r_rd_sel;
      h_blank     <= r_blank_vld ? (NUM_STRINGS'(1'b1) << r_blank_sel) : '0;
      pixel_valid <= r_cap_vld ? (NUM_STRINGS'(1'b1) << r_cap_sel) : '0;
      pixel_data  <= r_cap_vld ? mem_rdata : pixel_data;
    end
  end

endmodule

// File: tb/tb_string_scheduler.sv
// Self-checking bench for string_scheduler: event logs scored against per-string
// pixel sequences, fetch latency, round-robin order and frame completion rules.
module tb_string_scheduler;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_busy, frame_done, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_rdata = 24'h000000;
  logic [N-1:0]  string_ready = '1;
  logic [23:0]   pixel_data;
  logic [N-1:0]  pixel_valid, h_blank;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int           rd_cyc[$], rd_addr[$], pv_cyc[$], bl_cyc[$], bl_str[$], done_cyc[$];
  logic [N-1:0] pv_vec[$];
  logic [23:0]  pv_data[$];
  logic [N-1:0] rdy_hist [int];

  string_scheduler #(.NUM_STRINGS(N), .LEDS_PER_STRING(L), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_busy(frame_busy),
    .frame_done(frame_done), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .string_ready(string_ready), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .h_blank(h_blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM[a] = a, valid only in the cycle after the read strobe
  always @(posedge clk) mem_rdata <= mem_rd ? 24'(mem_addr) : 24'hBADBAD;

  always @(negedge clk) begin
    rdy_hist[cyc] = string_ready;
    if (mem_rd === 1'b1) begin rd_cyc.push_back(cyc); rd_addr.push_back(int'(mem_addr)); end
    if (pixel_valid !== '0 && !$isunknown(pixel_valid)) begin
      pv_cyc.push_back(cyc); pv_vec.push_back(pixel_valid); pv_data.push_back(pixel_data);
    end
    for (int s = 0; s < N; s++)
      if (h_blank[s] === 1'b1) begin bl_cyc.push_back(cyc); bl_str.push_back(s); end
    if (frame_done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); pv_cyc.delete(); pv_vec.delete(); pv_data.delete();
    bl_cyc.delete(); bl_str.delete(); done_cyc.delete();
  endtask

  task automatic do_reset();
    frame_start = 1'b0; string_ready = '1;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int k = 0;
    while (done_cyc.size() == 0 && k < max_cyc) begin @(negedge clk); k++; end
    n_checks++;
    if (done_cyc.size() == 0) begin
      n_fail++; $display("FAIL %s done_timeout: no frame_done within %0d cycles", tag, max_cyc);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Score a completed frame against the per-string rules
  task automatic check_frame(input string tag);
    int got[N]; int last_pix[N]; int nbl[N];
    int max_bl; int s; int exp_a; int fa; bit found;
    for (int i = 0; i < N; i++) begin got[i] = 0; last_pix[i] = -1; nbl[i] = 0; end
    max_bl = -1;
    n_checks++;
    if (rd_cyc.size() != N*L) begin
      n_fail++; $display("FAIL %s read_count: got %0d, expected %0d", tag, rd_cyc.size(), N*L);
    end
    foreach (rd_cyc[i]) begin
      s = rd_addr[i] / L;
      n_checks++;
      if (s >= N) begin
        n_fail++; $display("FAIL %s read_range: addr %0d, expected < %0d", tag, rd_addr[i], N*L);
      end else if (rdy_hist[rd_cyc[i]-1][s] !== 1'b1) begin
        n_fail++; $display("FAIL %s read_ready: string %0d read at cycle %0d with ready=0 on grant, expected 1", tag, s, rd_cyc[i]);
      end
    end
    foreach (pv_cyc[i]) begin
      n_checks++;
      if (!$onehot(pv_vec[i])) begin
        n_fail++; $display("FAIL %s pv_onehot: got %b, expected one-hot", tag, pv_vec[i]);
      end else begin
        s = 0;
        for (int b = 0; b < N; b++) if (pv_vec[i][b]) s = b;
        exp_a = s*L + got[s];
        found = 1'b0; fa = -1;
        foreach (rd_cyc[j]) if (rd_cyc[j] == pv_cyc[i] - 2) begin found = 1'b1; fa = rd_addr[j]; end
        n_checks++;
        if (!found || fa != exp_a) begin
          n_fail++; $display("FAIL %s pv_latency_addr: string %0d read 2 cycles earlier addr %0d (found %0b), expected %0d", tag, s, fa, found, exp_a);
        end
        n_checks++;
        if (pv_data[i] !== 24'(exp_a)) begin
          n_fail++; $display("FAIL %s pv_data: string %0d got %h, expected %h", tag, s, pv_data[i], 24'(exp_a));
        end
        got[s]++; last_pix[s] = pv_cyc[i];
      end
    end
    foreach (bl_cyc[i]) begin
      s = bl_str[i];
      n_checks++;
      if (nbl[s] != 0 || got[s] != L || bl_cyc[i] <= last_pix[s]) begin
        n_fail++; $display("FAIL %s blank_order: string %0d blank at %0d (prior blanks %0d, last pixel %0d, pixels %0d), expected once after %0d pixels", tag, s, bl_cyc[i], nbl[s], last_pix[s], got[s], L);
      end
      nbl[s]++;
      if (bl_cyc[i] > max_bl) max_bl = bl_cyc[i];
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (got[i] != L || nbl[i] != 1) begin
        n_fail++; $display("FAIL %s string_totals: string %0d got %0d pixels %0d blanks, expected %0d and 1", tag, i, got[i], nbl[i], L);
      end
    end
    n_checks++;
    if (done_cyc.size() != 1) begin
      n_fail++; $display("FAIL %s done_count: got %0d, expected 1", tag, done_cyc.size());
    end else begin
      n_checks++;
      if (done_cyc[0] <= max_bl) begin
        n_fail++; $display("FAIL %s done_after_blank: done at %0d, expected after %0d", tag, done_cyc[0], max_bl);
      end
    end
    n_checks++;
    if (frame_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_after: got %b, expected 0", tag, frame_busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; #1;
    n_checks++;
    if ({frame_busy, frame_done, mem_rd, mem_addr, pixel_data, pixel_valid, h_blank} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b rd=%b addr=%h data=%h pv=%b hb=%b, expected all 0", frame_busy, frame_done, mem_rd, mem_addr, pixel_data, pixel_valid, h_blank);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (frame_busy !== 1'b0 || rd_cyc.size() != 0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b reads=%0d, expected 0 and 0", frame_busy, rd_cyc.size());
    end
  endtask

  task automatic test_basic();
    do_reset(); clear_logs(); start_frame();
    n_checks++;
    if (frame_busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got %b, expected 1", frame_busy);
    end
    wait_done(300, "basic");
    for (int k = 0; k < N*L; k++) begin
      n_checks++;
      if (k >= rd_addr.size() || rd_addr[k] != (k % N)*L + k / N) begin
        n_fail++; $display("FAIL basic_addr_order: read %0d got %0d, expected %0d", k, (k < rd_addr.size()) ? rd_addr[k] : -1, (k % N)*L + k / N);
      end
    end
    check_frame("basic");
  endtask

  task automatic test_back_to_back();
    int prev[N];
    clear_logs(); start_frame();
    wait_done(300, "rr");
    for (int i = 0; i < N; i++) prev[i] = -100;
    foreach (rd_cyc[k]) begin
      n_checks++;
      if (rd_addr[k] / L != k % N) begin
        n_fail++; $display("FAIL rr_order: read %0d went to string %0d, expected %0d", k, rd_addr[k] / L, k % N);
      end else begin
        n_checks++;
        if (rd_cyc[k] - prev[k % N] < 4) begin
          n_fail++; $display("FAIL rr_spacing: string %0d regranted after %0d cycles, expected >= 4", k % N, rd_cyc[k] - prev[k % N]);
        end
        prev[k % N] = rd_cyc[k];
      end
    end
    check_frame("back_to_back");
  endtask

  task automatic test_stall();
    int c0; int c1; int s0_in; int others;
    do_reset(); clear_logs(); start_frame();
    @(posedge clk); #1 string_ready[0] = 1'b0; c0 = cyc;
    repeat (20) @(posedge clk);
    #1 string_ready[0] = 1'b1; c1 = cyc;
    wait_done(300, "stall");
    s0_in = 0; others = 0;
    foreach (rd_cyc[i])
      if (rd_cyc[i] > c0 && rd_cyc[i] <= c1) begin
        if (rd_addr[i] < L) s0_in++; else others++;
      end
    n_checks++;
    if (s0_in != 0) begin
      n_fail++; $display("FAIL stall_s0_reads: got %0d reads for string 0 during stall, expected 0", s0_in);
    end
    n_checks++;
    if (others == 0) begin
      n_fail++; $display("FAIL stall_others: got 0 reads for other strings during stall, expected > 0");
    end
    n_checks++;
    if (done_cyc.size() == 0 || done_cyc[0] <= c1) begin
      n_fail++; $display("FAIL stall_done_time: done at %0d, expected after ready return %0d", (done_cyc.size() != 0) ? done_cyc[0] : -1, c1);
    end
    check_frame("stall");
  endtask

  task automatic test_busy_restart();
    do_reset(); clear_logs(); start_frame();
    repeat (4) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_done(300, "restart");
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (rd_addr.size() == 0 || rd_addr[0] != 0) begin
      n_fail++; $display("FAIL restart_first_addr: got %0d, expected 0", (rd_addr.size() != 0) ? rd_addr[0] : -1);
    end
    n_checks++;
    if (done_cyc.size() != 0 && rd_cyc.size() != 0 && rd_cyc[rd_cyc.size()-1] > done_cyc[0]) begin
      n_fail++; $display("FAIL restart_reads_after_done: last read %0d, expected before done %0d", rd_cyc[rd_cyc.size()-1], done_cyc[0]);
    end
    check_frame("busy_restart");
  endtask

  task automatic test_reset_mid_frame();
    int nrd; int t_rst; int late_pv;
    do_reset(); clear_logs(); start_frame();
    repeat (8) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1; t_rst = cyc; #1;
    n_checks++;
    if ({frame_busy, frame_done, mem_rd, mem_addr, pixel_valid, h_blank} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy=%b done=%b rd=%b addr=%h pv=%b hb=%b, expected all 0", frame_busy, frame_done, mem_rd, mem_addr, pixel_valid, h_blank);
    end
    nrd = rd_cyc.size();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    late_pv = 0;
    foreach (pv_cyc[i]) if (pv_cyc[i] > t_rst) late_pv++;
    foreach (bl_cyc[i]) if (bl_cyc[i] > t_rst) late_pv++;
    n_checks++;
    if (done_cyc.size() != 0 || frame_busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_done: done pulses %0d busy %b, expected 0 and 0", done_cyc.size(), frame_busy);
    end
    n_checks++;
    if (rd_cyc.size() != nrd || late_pv != 0) begin
      n_fail++; $display("FAIL midrst_abandon: extra reads %0d strobes %0d after reset, expected 0 and 0", rd_cyc.size() - nrd, late_pv);
    end
    clear_logs(); start_frame();
    wait_done(300, "midrst_new");
    n_checks++;
    if (rd_addr.size() == 0 || rd_addr[0] != 0) begin
      n_fail++; $display("FAIL midrst_first_addr: got %0d, expected 0", (rd_addr.size() != 0) ? rd_addr[0] : -1);
    end
    check_frame("reset_new_frame");
  endtask

  task automatic test_random();
    int k;
    for (int f = 0; f < 3; f++) begin
      clear_logs(); start_frame();
      k = 0;
      while (done_cyc.size() == 0 && k < 600) begin
        @(posedge clk); #1;
        for (int s = 0; s < N; s++) string_ready[s] = ($urandom_range(3) != 0);
        k++;
      end
      string_ready = '1;
      wait_done(50, "random");
      check_frame("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_busy_restart();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit");
  end

endmodule
